// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the TPU array blocks
package tpu_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_READ,
      ST_DONE
   } os_ctrl_state_e;
   // Wavefront skew, hop latency, buffer read latency and the accumulator register
   function automatic int os_drain_cycles(input int rows, input int cols, input int rd_lat);
      return rows + cols - 2 + rd_lat + 1;
   endfunction
endpackage

// File: rtl/os_array_ctrl.sv
// os_array_ctrl: job sequencer (clear, feed, drain, readout) for the output-stationary MAC array
module os_array_ctrl
   import tpu_pkg::*;
#(
   parameter int ARRAY_ROWS = 4,
   parameter int ARRAY_COLS = 4,
   parameter int K_WIDTH    = 16,
   parameter int RD_LAT     = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [K_WIDTH-1:0]            k_len_i,
   input  logic                          abort_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          clear_o,
   output logic                          rd_en_o,
   output logic [K_WIDTH-1:0]            rd_addr_o,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [$clog2(ARRAY_ROWS)-1:0] res_row_o
);
   localparam int D  = os_drain_cycles(ARRAY_ROWS, ARRAY_COLS, RD_LAT);
   localparam int DW = $clog2(D + 1);
   localparam int CW = K_WIDTH > DW ? K_WIDTH : DW;
   localparam int RW = $clog2(ARRAY_ROWS);

   os_ctrl_state_e       state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [K_WIDTH-1:0]   k_len_q;
   logic [K_WIDTH-1:0]   k_last;
   logic                 cnt_inc;

   assign k_last  = k_len_q - 1'b1;
   assign cnt_inc = state_q == ST_FEED || state_q == ST_DRAIN || (state_q == ST_READ && res_ready_i);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = start_i ? ST_CLEAR : ST_IDLE;
         ST_CLEAR: state_d = k_len_q != '0 ? ST_FEED : ST_DRAIN;
         ST_FEED:  state_d = cnt_q == CW'(k_last) ? ST_DRAIN : ST_FEED;
         ST_DRAIN: state_d = cnt_q == CW'(D - 1) ? ST_READ : ST_DRAIN;
         ST_READ:  state_d = res_ready_i && cnt_q == CW'(ARRAY_ROWS - 1) ? ST_DONE : ST_READ;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_i && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   // Counter restarts from zero on every state change, so each phase counts up from 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         k_len_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= state_d != state_q ? '0 : cnt_inc ? cnt_q + 1'b1 : cnt_q;
         if (state_q == ST_IDLE && start_i) k_len_q <= k_len_i;
      end
   end

   assign busy_o      = state_q != ST_IDLE;
   assign done_o      = state_q == ST_DONE;
   assign clear_o     = state_q == ST_CLEAR;
   assign rd_en_o     = state_q == ST_FEED;
   assign rd_addr_o   = rd_en_o ? cnt_q[K_WIDTH-1:0] : '0;
   assign res_valid_o = state_q == ST_READ;
   assign res_row_o   = res_valid_o ? cnt_q[RW-1:0] : '0;
endmodule
